// File: rtl/sm_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sm_mem_arbiter
//
// Two-master arbiter in front of a single-ported synchronous memory. Each
// granted request takes exactly three cycles: IDLE (request sampled),
// ACCESS (memory strobed), RESP (ack plus read data back to the winner).
// Ties are broken round-robin, so a master that keeps requesting waits for
// at most one access by the other master.
//
// Parameters
//   ADDR_W      word-address width
//   DATA_W      data width
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   m0_req      master 0 request, held until m0_ack
//   m0_addr     master 0 word address
//   m0_we       master 0 write (1) / read (0)
//   m0_wdata    master 0 write data
//   m0_ack      master 0 one-cycle completion pulse
//   m0_rdata    master 0 read data, non-zero only with m0_ack on a read
//   m1_*        same set for master 1
//   s_en        memory access strobe (ACCESS cycle only)
//   s_we        memory write enable, qualified by s_en
//   s_addr      registered memory address
//   s_wdata     registered memory write data
//   s_rdata     memory read data, valid the cycle after s_en
//   busy        high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module sm_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              s_en,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                win_reg, win_next;     // latched winner: 0 = M0, 1 = M1
    logic                last_reg, last_next;   // master granted most recently
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;

    // Master-indexed views of the request ports so the grant path can simply
    // index by the winning id.
    logic [1:0]          req_vec;
    logic [1:0]          we_vec;
    logic [ADDR_W-1:0]   addr_vec  [2];
    logic [DATA_W-1:0]   wdata_vec [2];
    logic [1:0]          ack_vec;
    logic [DATA_W-1:0]   rdata_vec [2];

    logic                grant_id;

    assign req_vec      = {m1_req, m0_req};
    assign we_vec       = {m1_we, m0_we};
    assign addr_vec[0]  = m0_addr;
    assign addr_vec[1]  = m1_addr;
    assign wdata_vec[0] = m0_wdata;
    assign wdata_vec[1] = m1_wdata;

    // Sole requester wins outright; on a tie the master not granted last
    // wins. With no request the value is unused.
    assign grant_id = (req_vec == 2'b11) ? ~last_reg : req_vec[1];

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            win_reg   <= 1'b0;
            last_reg  <= 1'b1;      // M1 counted as last, so M0 wins the first tie
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
            last_reg  <= last_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        last_next  = last_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;

        case (state_reg)
            ST_IDLE: begin
                // Requests are only looked at here; anything raised and
                // dropped between edges, or raised during ACCESS/RESP, is
                // simply evaluated at the next IDLE edge.
                if (|req_vec) begin
                    state_next = ST_ACCESS;
                    win_next   = grant_id;
                    last_next  = grant_id;
                    we_next    = we_vec[grant_id];
                    addr_next  = addr_vec[grant_id];
                    wdata_next = wdata_vec[grant_id];
                end
            end
            // Once issued, an access always runs to completion even if the
            // winner drops its request.
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        s_en = (state_reg == ST_ACCESS);
        s_we = (state_reg == ST_ACCESS) && we_reg;
        busy = (state_reg != ST_IDLE);
    end

    assign s_addr  = addr_reg;
    assign s_wdata = wdata_reg;

    // Per-master response: ack only for the latched winner during RESP, read
    // data passed through only alongside that ack and only for reads.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi]   = (state_reg == ST_RESP) && (win_reg == (gi == 1));
            assign rdata_vec[gi] = (ack_vec[gi] && !we_reg) ? s_rdata : '0;
        end
    endgenerate

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign m0_rdata = rdata_vec[0];
    assign m1_rdata = rdata_vec[1];

endmodule

// File: tb/tb_sm_mem_arbiter.sv
module tb_sm_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] C1 = 32'h12345678;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic          m0_we = 1'b0, m1_we = 1'b0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_en, s_we, busy;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;

    sm_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory contents at start of test
    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return DB;
        if (i == 32) return C1;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    // Synchronous memory behind the arbiter: read data one cycle after s_en
    logic        mem_load = 1'b1;
    logic [31:0] smem [256];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) smem[i] <= init_val(i);
            s_rdata <= '0;
        end else if (s_en) begin
            if (s_we) smem[s_addr[7:0]] <= s_wdata;
            else      s_rdata <= smem[s_addr[7:0]];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %b required %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction granted at edge t_start shows its
    // strobe in the cycle after that edge, its ack one cycle later, and the
    // next grant can happen no earlier than edge t_start+3.
    // ------------------------------------------------------------------
    int          edge_n  = 0;
    int          t_start = -100;
    bit          m_win, m_we, m_last = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rexp = '0;
    logic [31:0] rmem [256];

    task automatic model_reset();
        t_start = edge_n - 100;
        m_win = 1'b0; m_we = 1'b0; m_last = 1'b1;
        m_addr = '0; m_wdata = '0; m_rexp = '0;
    endtask

    task automatic model_edge(input bit r0, input bit r1, input bit we0, input bit we1,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1);
        edge_n++;
        // The memory operation of a granted access happens at the edge that
        // ends its strobe cycle.
        if (edge_n - t_start == 1) begin
            if (m_we) rmem[m_addr[7:0]] = m_wdata;
            else      m_rexp = rmem[m_addr[7:0]];
        end
        if ((edge_n - t_start >= 3) && (r0 || r1)) begin
            if (r0 && r1)  m_win = !m_last;
            else if (r0)   m_win = 1'b0;
            else           m_win = 1'b1;
            m_last  = m_win;
            t_start = edge_n;
            m_we    = m_win ? we1 : we0;
            m_addr  = m_win ? a1  : a0;
            m_wdata = m_win ? d1  : d0;
        end
    endtask

    task automatic model_check();
        int k;
        bit in_acc, in_rsp;
        k = edge_n - t_start;
        in_acc = (k == 0);
        in_rsp = (k == 1);
        chk1 ("mdl_s_en",   s_en,   in_acc);
        chk1 ("mdl_s_we",   s_we,   in_acc && m_we);
        chk1 ("mdl_busy",   busy,   in_acc || in_rsp);
        chk1 ("mdl_m0_ack", m0_ack, in_rsp && !m_win);
        chk1 ("mdl_m1_ack", m1_ack, in_rsp && m_win);
        chk32("mdl_m0_rdata", m0_rdata, (in_rsp && !m_win && !m_we) ? m_rexp : 32'h0);
        chk32("mdl_m1_rdata", m1_rdata, (in_rsp && m_win && !m_we) ? m_rexp : 32'h0);
        chk32("mdl_s_addr",  s_addr,  m_addr);
        chk32("mdl_s_wdata", s_wdata, m_wdata);
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the
    // following falling edge.
    task automatic run_cycle(input bit r0, input bit r1, input bit we0, input bit we1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
        m0_req = r0; m1_req = r1; m0_we = we0; m1_we = we1;
        m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1;
        @(posedge clk);
        model_edge(r0, r1, we0, we1, a0, a1, d0, d1);
        @(negedge clk);
        model_check();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk1 ("rst_s_en",   s_en,   1'b0);
        chk1 ("rst_s_we",   s_we,   1'b0);
        chk1 ("rst_busy",   busy,   1'b0);
        chk1 ("rst_m0_ack", m0_ack, 1'b0);
        chk1 ("rst_m1_ack", m1_ack, 1'b0);
        chk32("rst_s_addr",  s_addr,  32'h0);
        chk32("rst_s_wdata", s_wdata, 32'h0);
        chk32("rst_m0_rdata", m0_rdata, 32'h0);
        chk32("rst_m1_rdata", m1_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: inputs before an edge, outputs expected in the
    // cycle after it.
    // ------------------------------------------------------------------
    typedef struct {
        bit          rst;
        bit          r0, r1, we0, we1;
        logic [31:0] a0, a1, d;
        bit          e_sen, e_swe, e_ack0, e_ack1, e_busy;
        logic [31:0] e_rd0, e_rd1;
    } vec_t;

    function automatic vec_t v(input bit rst, input bit r0, input bit r1,
                               input bit we0, input bit we1,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d,
                               input bit sen, input bit swe, input bit k0, input bit k1,
                               input bit bsy, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t x;
        x.rst = rst; x.r0 = r0; x.r1 = r1; x.we0 = we0; x.we1 = we1;
        x.a0 = a0; x.a1 = a1; x.d = d;
        x.e_sen = sen; x.e_swe = swe; x.e_ack0 = k0; x.e_ack1 = k1; x.e_busy = bsy;
        x.e_rd0 = rd0; x.e_rd1 = rd1;
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        bit          rr0, rr1, rw0, rw1;
        logic [31:0] ra0, ra1, rd0, rd1;

        for (int i = 0; i < 256; i++) rmem[i] = init_val(i);

        // Both masters hold req for 12 cycles: M0, M1, M0, M1 every 3 cycles
        for (int rep = 0; rep < 2; rep++) begin
            tbl.push_back(v(rep == 0, 1, 1, 0, 0, 'h10, 'h20, 0, 1, 0, 0, 0, 1, 0, 0));
            tbl.push_back(v(0,        1, 1, 0, 0, 'h10, 'h20, 0, 0, 0, 1, 0, 1, DB, 0));
            tbl.push_back(v(0,        1, 1, 0, 0, 'h10, 'h20, 0, 0, 0, 0, 0, 0, 0, 0));
            tbl.push_back(v(0,        1, 1, 0, 0, 'h10, 'h20, 0, 1, 0, 0, 0, 1, 0, 0));
            tbl.push_back(v(0,        1, 1, 0, 0, 'h10, 'h20, 0, 0, 0, 0, 1, 1, 0, C1));
            tbl.push_back(v(0,        1, 1, 0, 0, 'h10, 'h20, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        // Single M0 read of 0x10
        tbl.push_back(v(1, 1, 0, 0, 0, 'h10, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 'h10, 0, 0, 0, 0, 1, 0, 1, DB, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0));
        // M1 writes 0x5, then M0 reads it back
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 'h5, A5, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 'h5, A5, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 'h5, 0, 0,  1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 'h5, 0, 0,  0, 0, 1, 0, 1, A5, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 0, 0, 0, 0, 0));
        // Only M1 requests for 9 cycles
        for (int j = 0; j < 9; j++) begin
            case (j % 3)
                0:       tbl.push_back(v(j == 0, 0, 1, 0, 0, 0, 'h20, 0, 1, 0, 0, 0, 1, 0, 0));
                1:       tbl.push_back(v(0,      0, 1, 0, 0, 0, 'h20, 0, 0, 0, 0, 1, 1, 0, C1));
                default: tbl.push_back(v(0,      0, 1, 0, 0, 0, 'h20, 0, 0, 0, 0, 0, 0, 0, 0));
            endcase
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_load = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].rst) apply_reset();
            run_cycle(tbl[i].r0, tbl[i].r1, tbl[i].we0, tbl[i].we1,
                      tbl[i].a0, tbl[i].a1, tbl[i].d, tbl[i].d);
            chk1 ($sformatf("vec%0d_s_en", i),   s_en,   tbl[i].e_sen);
            chk1 ($sformatf("vec%0d_s_we", i),   s_we,   tbl[i].e_swe);
            chk1 ($sformatf("vec%0d_m0_ack", i), m0_ack, tbl[i].e_ack0);
            chk1 ($sformatf("vec%0d_m1_ack", i), m1_ack, tbl[i].e_ack1);
            chk1 ($sformatf("vec%0d_busy", i),   busy,   tbl[i].e_busy);
            chk32($sformatf("vec%0d_m0_rdata", i), m0_rdata, tbl[i].e_rd0);
            chk32($sformatf("vec%0d_m1_rdata", i), m1_rdata, tbl[i].e_rd1);
        end

        // Reset asserted mid-ACCESS: strobe drops at once, no ack afterwards,
        // and the pointer is back to favouring M0.
        apply_reset();
        run_cycle(1, 0, 0, 0, 'h30, 0, 0, 0);
        chk1("rstmid_pre_s_en", s_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1 ("rstmid_s_en",   s_en,   1'b0);
        chk1 ("rstmid_busy",   busy,   1'b0);
        chk32("rstmid_s_addr", s_addr, 32'h0);
        m0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk1("rstmid_no_ack_a", m0_ack, 1'b0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk1("rstmid_no_ack_b", m0_ack, 1'b0);
        run_cycle(1, 1, 0, 0, 'h40, 'h50, 0, 0);
        chk32("rstmid_tie_s_addr", s_addr, 32'h40);
        run_cycle(1, 1, 0, 0, 'h40, 'h50, 0, 0);
        chk1("rstmid_tie_m0_ack", m0_ack, 1'b1);
        chk1("rstmid_tie_m1_ack", m1_ack, 1'b0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Request raised and withdrawn between two edges is never seen
        m1_req = 1'b1; m1_addr = 'h7;
        #3 m1_req = 1'b0;
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk1("withdrawn_s_en", s_en, 1'b0);
        chk1("withdrawn_busy", busy, 1'b0);

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) apply_reset();
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            rw0 = ($urandom_range(0, 1) == 1);
            rw1 = ($urandom_range(0, 1) == 1);
            ra0 = $urandom_range(0, 15);
            ra1 = $urandom_range(0, 15);
            rd0 = $urandom();
            rd1 = $urandom();
            run_cycle(rr0, rr1, rw0, rw1, ra0, ra1, rd0, rd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
